// File: rtl/instruction_decode_stage.sv
// Decode stage: register file with write-back bypass, branch resolution,
// wrong-path squash and the decode/execute pipeline register.
module instruction_decode_stage #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_REGS    = 8,
  parameter int FLUSH_SLOTS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           instruction,
  input  logic                  wb_en,
  input  logic [2:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  branch_en,
  output logic [5:0]            pc_offset,
  output logic                  ex_valid,
  output logic [3:0]            ex_opcode,
  output logic [2:0]            ex_rd,
  output logic [DATA_WIDTH-1:0] ex_op_a,
  output logic [DATA_WIDTH-1:0] ex_op_b,
  output logic [DATA_WIDTH-1:0] ex_imm
);

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b1000;
  localparam logic [3:0] OP_RSV0  = 4'b1001;
  localparam logic [3:0] OP_LOAD  = 4'b1010;
  localparam logic [3:0] OP_STORE = 4'b1011;
  localparam logic [3:0] OP_BEQ   = 4'b1100;
  localparam logic [3:0] OP_BNE   = 4'b1101;
  localparam logic [3:0] OP_JMP   = 4'b1110;

  localparam logic [1:0] FLUSH_LD = 2'(FLUSH_SLOTS);

  typedef struct packed {
    logic                  valid;
    logic [3:0]            opcode;
    logic [2:0]            rd;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] imm;
  } id_ex_t;

  logic [DATA_WIDTH-1:0] rf [NUM_REGS];
  logic [1:0]            flush_cnt;
  id_ex_t                id_ex_q;
  id_ex_t                id_ex_d;

  logic [3:0]            op;
  logic [2:0]            fa;
  logic [2:0]            fb;
  logic [2:0]            fc;
  logic [5:0]            imm6;
  logic [DATA_WIDTH-1:0] sext;

  assign op   = instruction[15:12];
  assign fa   = instruction[11:9];
  assign fb   = instruction[8:6];
  assign fc   = instruction[5:3];
  assign imm6 = instruction[5:0];
  assign sext = {{(DATA_WIDTH-6){imm6[5]}}, imm6};

  logic is_alu;
  logic is_imm;
  logic is_st;
  logic is_br;
  logic squash;

  assign is_alu = (op != OP_NOP) && !op[3];
  assign is_imm = (op == OP_ADDI) || (op == OP_LOAD);
  assign is_st  = (op == OP_STORE);
  assign is_br  = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_JMP);
  assign squash = rst || (flush_cnt != 2'd0);

  logic [2:0]            ra_a;
  logic [2:0]            ra_b;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  // Read-port address steering by instruction class
  always_comb begin
    ra_a = fb;
    ra_b = fc;
    unique case (1'b1)
      is_st:   ra_b = fa;
      is_br: begin
        ra_a = fa;
        ra_b = fb;
      end
      default: ;
    endcase
  end

  // Same-cycle write-back wins over the stored value
  always_comb begin
    rd_a = rf[ra_a];
    rd_b = rf[ra_b];
    if (wb_en && (wb_addr == ra_a)) rd_a = wb_data;
    if (wb_en && (wb_addr == ra_b)) rd_b = wb_data;
  end

  logic cond;

  always_comb begin
    cond = 1'b0;
    unique case (op)
      OP_BEQ:  cond = (rd_a == rd_b);
      OP_BNE:  cond = (rd_a != rd_b);
      OP_JMP:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign branch_en = !squash && is_br && cond;
  assign pc_offset = imm6;

  always_comb begin
    id_ex_d = '0;
    if (!squash) begin
      unique case (1'b1)
        is_alu: begin
          id_ex_d.op_a = rd_a;
          id_ex_d.op_b = rd_b;
        end
        is_imm: begin
          id_ex_d.op_a = rd_a;
          id_ex_d.op_b = sext;
        end
        is_st: begin
          id_ex_d.op_a = rd_a;
          id_ex_d.op_b = rd_b;
        end
        is_br: begin
          id_ex_d.op_a = rd_a;
          id_ex_d.op_b = rd_b;
        end
        default: ;
      endcase
      if (is_alu || is_imm || is_st || is_br) begin
        id_ex_d.valid  = 1'b1;
        id_ex_d.opcode = op;
        id_ex_d.rd     = fa;
        id_ex_d.imm    = sext;
      end else begin
        id_ex_d.op_a = '0;
        id_ex_d.op_b = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= 2'd0;
    end else if (branch_en) begin
      flush_cnt <= FLUSH_LD;
    end else if (flush_cnt != 2'd0) begin
      flush_cnt <= flush_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  assign ex_valid  = id_ex_q.valid;
  assign ex_opcode = id_ex_q.opcode;
  assign ex_rd     = id_ex_q.rd;
  assign ex_op_a   = id_ex_q.op_a;
  assign ex_op_b   = id_ex_q.op_b;
  assign ex_imm    = id_ex_q.imm;

  logic unused;
  assign unused = (OP_RSV0 == 4'b1001);

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: directed cases plus random
// stimulus against a behavioural model of the decode rules.
module tb_instruction_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instruction;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        branch_en;
  logic [5:0]  pc_offset;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [2:0]  ex_rd;
  logic [15:0] ex_op_a;
  logic [15:0] ex_op_b;
  logic [15:0] ex_imm;

  instruction_decode_stage #(
    .DATA_WIDTH(16), .NUM_REGS(8), .FLUSH_SLOTS(1)
  ) dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .branch_en(branch_en), .pc_offset(pc_offset),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [15:0] m_rf [8];
  int          m_skip;
  logic        obs_br;
  logic [5:0]  obs_off;

  function automatic logic [15:0] rdv(input logic [2:0] a, input logic we,
                                      input logic [2:0] wa,
                                      input logic [15:0] wd);
    return (we && wa == a) ? wd : m_rf[a];
  endfunction

  task automatic step(input logic r, input logic [15:0] ins,
                      input logic we, input logic [2:0] wa,
                      input logic [15:0] wd);
    int          op;
    logic [2:0]  fa, fb, fc;
    logic [15:0] sx, a, b;
    logic        v, tk;
    @(negedge clk);
    rst = r; instruction = ins;
    wb_en = we; wb_addr = wa; wb_data = wd;
    op = int'(ins[15:12]);
    fa = ins[11:9]; fb = ins[8:6]; fc = ins[5:3];
    sx = 16'($signed(ins[5:0]));
    v  = !r && m_skip == 0 && op != 0 && op != 9 && op != 15;
    a = 0; b = 0; tk = 0;
    if (v) begin
      if (op >= 12) begin
        a = rdv(fa, we, wa, wd);
        b = rdv(fb, we, wa, wd);
        tk = (op == 14) || (op == 12 && a == b) || (op == 13 && a != b);
      end else begin
        a = rdv(fb, we, wa, wd);
        if (op <= 7)       b = rdv(fc, we, wa, wd);
        else if (op == 11) b = rdv(fa, we, wa, wd);
        else               b = sx;
      end
    end
    #1;
    obs_br = branch_en; obs_off = pc_offset;
    chk("branch_en", 16'(branch_en), 16'(tk));
    chk("pc_offset", 16'(pc_offset), 16'(ins[5:0]));
    if (r) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 0;
      m_skip = 0;
    end else begin
      if (we) m_rf[wa] = wd;
      if (tk)          m_skip = 1;
      else if (m_skip > 0) m_skip--;
    end
    @(posedge clk);
    #1;
    chk("ex_valid",  16'(ex_valid),  16'(v));
    chk("ex_opcode", 16'(ex_opcode), v ? 16'(op) : 16'h0);
    chk("ex_rd",     16'(ex_rd),     v ? 16'(fa) : 16'h0);
    chk("ex_op_a",   ex_op_a, a);
    chk("ex_op_b",   ex_op_b, b);
    chk("ex_imm",    ex_imm,  v ? sx : 16'h0);
  endtask

  task automatic nop();
    step(1'b0, 16'h0000, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 16'h0000, 1'b0, 3'd0, 16'h0);
    step(1'b1, 16'h0000, 1'b0, 3'd0, 16'h0);
  endtask

  initial begin
    logic [15:0] ins;
    logic [3:0]  opsel;
    rst = 1'b1; instruction = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
    m_skip = 0;

    do_reset();
    chk("tp_reset_valid", 16'(ex_valid), 16'h0);
    for (int i = 0; i < 3; i++) nop();

    step(1'b0, 16'h1658, 1'b1, 3'd1, 16'h00A5);
    chk("tp_bypass_br", 16'(obs_br), 16'h0);
    chk("tp_bypass_a", ex_op_a, 16'h00A5);
    chk("tp_bypass_rd", 16'(ex_rd), 16'h3);

    do_reset();
    step(1'b0, 16'hC047, 1'b0, 3'd0, 16'h0);
    chk("tp_beq_taken", 16'(obs_br), 16'h1);
    chk("tp_beq_off", 16'(obs_off), 16'h7);
    step(1'b0, 16'h1400, 1'b0, 3'd0, 16'h0);
    chk("tp_squash", 16'(ex_valid), 16'h0);
    step(1'b0, 16'h1400, 1'b0, 3'd0, 16'h0);
    chk("tp_after_squash", 16'(ex_valid), 16'h1);

    step(1'b0, 16'h0000, 1'b1, 3'd0, 16'h0005);
    step(1'b0, 16'hC047, 1'b0, 3'd0, 16'h0);
    chk("tp_beq_not", 16'(obs_br), 16'h0);
    step(1'b0, 16'hD047, 1'b0, 3'd0, 16'h0);
    chk("tp_bne_taken", 16'(obs_br), 16'h1);
    nop();
    step(1'b0, 16'hE03A, 1'b0, 3'd0, 16'h0);
    chk("tp_jmp_off", 16'(obs_off), 16'h003A);
    chk("tp_jmp_imm", ex_imm, 16'hFFFA);
    nop();

    step(1'b0, 16'h0000, 1'b1, 3'd3, 16'h1234);
    step(1'b0, 16'h0000, 1'b1, 3'd0, 16'h0010);
    step(1'b0, 16'hB600, 1'b0, 3'd0, 16'h0);
    chk("tp_st_a", ex_op_a, 16'h0010);
    chk("tp_st_b", ex_op_b, 16'h1234);

    do_reset();
    step(1'b0, 16'hC047, 1'b0, 3'd0, 16'h0);
    step(1'b1, 16'hC047, 1'b0, 3'd0, 16'h0);
    step(1'b0, 16'hC047, 1'b0, 3'd0, 16'h0);
    chk("tp_rst_cancel", 16'(obs_br), 16'h1);
    nop();

    for (int n = 0; n < 400; n++) begin
      opsel = 4'($urandom_range(0, 15));
      ins = 16'($urandom);
      ins[15:12] = opsel;
      step(($urandom_range(0, 49) == 0), ins,
           1'($urandom), 3'($urandom),
           ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3))
                                       : 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
